// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit producing HI/LO
// Divider datapath is compiled in only when MDU_DIV_EN is defined.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;

  logic               op_div;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign a_neg    = op[0] & a[WIDTH-1];
  assign b_neg    = op[0] & b[WIDTH-1];
  assign abs_a    = a_neg ? -a : a;
  assign abs_b    = b_neg ? -b : b;
  // Shift-add: upper half accumulates, multiplier drains out of the lower half.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;

`ifdef MDU_DIV_EN
  logic             div_zero;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Restoring step: acc holds {remainder, dividend/quotient}.
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
  assign quot_fix = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op[1]) begin
`ifdef MDU_DIV_EN
            state_nxt = (b == '0) ? FIX : RUN;
`else
            state_nxt = FIX;
`endif
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      op_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef MDU_DIV_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div <= op[1];
            neg_a  <= a_neg;
            neg_b  <= b_neg;
            mcand  <= abs_b;
            acc    <= {{WIDTH{1'b0}}, abs_a};
            cnt    <= '0;
`ifdef MDU_DIV_EN
            div_zero <= op[1] && (b == '0);
            // Divide by zero returns the raw dividend in hi and all ones in lo.
            if (op[1] && (b == '0)) acc <= {a, {WIDTH{1'b1}}};
`endif
          end else begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
`ifdef MDU_DIV_EN
          if (op_div) begin
            if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else
`endif
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FIX: begin
          done <= 1'b1;
          if (!op_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
`ifdef MDU_DIV_EN
          else if (div_zero) begin
            hi <= acc[2*WIDTH-1:WIDTH];
            lo <= acc[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
